logic_gates_bist: RTL and testbench

Synthesizable self-test controller for the two-input gate unit (AND/OR/XOR/NAND/NOR/XNOR outputs). It drives the unit's A/B inputs through all four input vectors and samples the six gate outputs. Each sample is compared against a built-in golden model, and per-vector and per-gate failure information is latched. It sits beside the gate unit as its on-chip stimulus/response end, replacing a simulation-only stimulus driver.

---
 rtl/logic_gates_pkg.sv | 22 ++
 rtl/logic_gates_golden.sv | 26 ++
 rtl/logic_gates_bist.sv | 120 ++++++++++++
 tb/tb_logic_gates_bist.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/logic_gates_pkg.sv
// Shared definitions for the two-input gate unit self-test.
// State encoding, vector/gate counts and response bit positions.
package logic_gates_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int NUM_GATES   = 6;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XNOR = 5;

endpackage

// File: rtl/logic_gates_golden.sv
// Golden response of the gate unit for one {A,B} vector.
// Bit positions follow the GATE_* constants.
import logic_gates_pkg::*;

module logic_gates_golden (
  input  logic [1:0]           vec_i,
  output logic [NUM_GATES-1:0] exp_o
);

  logic a;
  logic b;

  assign a = vec_i[1];
  assign b = vec_i[0];

  always_comb begin
    exp_o            = '0;
    exp_o[GATE_AND]  = a & b;
    exp_o[GATE_OR]   = a | b;
    exp_o[GATE_XOR]  = a ^ b;
    exp_o[GATE_NAND] = ~(a & b);
    exp_o[GATE_NOR]  = ~(a | b);
    exp_o[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/logic_gates_bist.sv
// Self-test controller: walks {A,B} through 00..11, compares the
// six gate outputs to the golden model and latches failures.
import logic_gates_pkg::*;

module logic_gates_bist #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   a_out,
  output logic                   b_out,
  input  logic                   and_in,
  input  logic                   or_in,
  input  logic                   xor_in,
  input  logic                   nand_in,
  input  logic                   nor_in,
  input  logic                   xnor_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] fail_vec,
  output logic [NUM_GATES-1:0]   fail_mask,
  output logic [2:0]             err_count
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e                 state_q;
  logic [1:0]             vec_q;
  logic [1:0]             vec_d;
  logic [3:0]             cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [NUM_VECTORS-1:0] fail_vec_q;
  logic [NUM_GATES-1:0]   fail_mask_q;
  logic [NUM_GATES-1:0]   fail_mask_d;
  logic [2:0]             err_q;

  logic [NUM_GATES-1:0]   resp;
  logic [NUM_GATES-1:0]   expd;
  logic [NUM_GATES-1:0]   diff;

  logic_gates_golden u_golden (
    .vec_i (vec_q),
    .exp_o (expd)
  );

  assign resp = {xnor_in, nor_in, nand_in,
                 xor_in, or_in, and_in};
  assign diff        = resp ^ expd;
  assign fail_mask_d = fail_mask_q | diff;
  assign vec_d       = vec_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= 2'd0;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= '0;
      fail_mask_q <= '0;
      err_q       <= 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_SETTLE;
            vec_q       <= 2'd0;
            cnt_q       <= CNT_LOAD;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
            err_q       <= 3'd0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CHECK: begin
          fail_mask_q <= fail_mask_d;
          if (|diff) begin
            fail_vec_q[vec_q] <= 1'b1;
            err_q             <= err_q + 3'd1;
          end
          if (vec_q != 2'd3) begin
            state_q <= S_SETTLE;
            vec_q   <= vec_d;
            cnt_q   <= CNT_LOAD;
          end else begin
            // Last vector: verdict must include this cycle's diff.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= ~|fail_mask_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {a_out, b_out} = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_vec       = fail_vec_q;
  assign fail_mask      = fail_mask_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_logic_gates_bist.sv
// Directed bench for logic_gates_bist with a behavioural gate unit
// that can be faulted; a second instance runs with SETTLE_CYCLES=3.
`timescale 1ns/1ps
module tb_logic_gates_bist;

  logic clk;
  logic rst;
  logic start0;
  logic start1;
  int   fault;
  int   checks;
  int   errors;

  logic a0, b0, a1, b1;
  logic and0, or0, xor0, nand0, nor0, xnor0;
  logic and1, or1, xor1, nand1, nor1, xnor1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [3:0] fvec0, fvec1;
  logic [5:0] fmask0, fmask1;
  logic [2:0] ecnt0, ecnt1;

  logic_gates_bist u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a_out(a0), .b_out(b0),
    .and_in(and0), .or_in(or0), .xor_in(xor0),
    .nand_in(nand0), .nor_in(nor0), .xnor_in(xnor0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_vec(fvec0), .fail_mask(fmask0), .err_count(ecnt0)
  );

  logic_gates_bist #(.SETTLE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_out(a1), .b_out(b1),
    .and_in(and1), .or_in(or1), .xor_in(xor1),
    .nand_in(nand1), .nor_in(nor1), .xnor_in(xnor1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fvec1), .fail_mask(fmask1), .err_count(ecnt1)
  );

  // Gate unit for instance 0: fault 1 = AND stuck 0, 2 = XOR/XNOR swapped
  always_comb begin
    and0  = (fault == 1) ? 1'b0 : (a0 & b0);
    or0   = a0 | b0;
    xor0  = (fault == 2) ? ~(a0 ^ b0) : (a0 ^ b0);
    nand0 = ~(a0 & b0);
    nor0  = ~(a0 | b0);
    xnor0 = (fault == 2) ? (a0 ^ b0) : ~(a0 ^ b0);
  end

  always_comb begin
    and1  = a1 & b1;
    or1   = a1 | b1;
    xor1  = a1 ^ b1;
    nand1 = ~(a1 & b1);
    nor1  = ~(a1 | b1);
    xnor1 = ~(a1 ^ b1);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start instance 0 and follow it to DONE; optional start pulse at pulse_edge.
  task automatic run0(input logic       ep,
                      input logic [3:0] ev,
                      input logic [5:0] em,
                      input logic [2:0] ec,
                      input int         pulse_edge);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("start_busy", 8'(busy0), 8'd1);
    check("start_done", 8'(done0), 8'd0);
    check("start_ab", 8'({a0, b0}), 8'd0);
    for (int e = 1; e <= 8; e++) begin
      if (e == pulse_edge) start0 = 1'b1;
      tick();
      start0 = 1'b0;
      if (e < 8) begin
        check("ab_seq", 8'({a0, b0}), 8'(e / 2));
        check("busy_run", 8'(busy0), 8'd1);
        check("done_early", 8'(done0), 8'd0);
      end else begin
        check("done_edge8", 8'(done0), 8'd1);
        check("busy_done", 8'(busy0), 8'd0);
        check("pass", 8'(pass0), 8'(ep));
        check("fail_vec", 8'(fvec0), 8'(ev));
        check("fail_mask", 8'(fmask0), 8'(em));
        check("err_count", 8'(ecnt0), 8'(ec));
        check("ab_hold", 8'({a0, b0}), 8'd3);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fault  = 0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    tick();
    tick();
    check("rst_busy", 8'(busy0), 8'd0);
    check("rst_done", 8'(done0), 8'd0);
    check("rst_pass", 8'(pass0), 8'd0);
    check("rst_ab", 8'({a0, b0}), 8'd0);
    check("rst_fvec", 8'(fvec0), 8'd0);
    check("rst_fmask", 8'(fmask0), 8'd0);
    check("rst_ecnt", 8'(ecnt0), 8'd0);
    rst = 1'b0;
    tick();

    run0(1'b1, 4'b0000, 6'b000000, 3'd0, 0);
    tick();
    check("done_hold", 8'(done0), 8'd1);
    check("pass_hold", 8'(pass0), 8'd1);

    fault = 1;
    run0(1'b0, 4'b1000, 6'b000001, 3'd1, 0);

    fault = 2;
    run0(1'b0, 4'b1111, 6'b100100, 3'd4, 0);

    // Reset during SETTLE of vector 1, after vector 0 already failed
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    check("mid_fvec", 8'(fvec0), 8'b0001);
    check("mid_ab", 8'({a0, b0}), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", 8'(busy0), 8'd0);
    check("mrst_done", 8'(done0), 8'd0);
    check("mrst_ab", 8'({a0, b0}), 8'd0);
    check("mrst_fvec", 8'(fvec0), 8'd0);
    check("mrst_ecnt", 8'(ecnt0), 8'd0);
    fault = 0;
    tick();
    run0(1'b1, 4'b0000, 6'b000000, 3'd0, 0);

    // Start pulse while busy is ignored; rerun from DONE
    fault = 1;
    run0(1'b0, 4'b1000, 6'b000001, 3'd1, 3);
    fault = 0;
    run0(1'b1, 4'b0000, 6'b000000, 3'd0, 5);

    // SETTLE_CYCLES=3 instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("s3_ab0", 8'({a1, b1}), 8'd0);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e < 16) begin
        check("s3_ab_seq", 8'({a1, b1}), 8'(e / 4));
        check("s3_done_early", 8'(done1), 8'd0);
      end else begin
        check("s3_done_edge16", 8'(done1), 8'd1);
        check("s3_pass", 8'(pass1), 8'd1);
        check("s3_fvec", 8'(fvec1), 8'd0);
        check("s3_ab_hold", 8'({a1, b1}), 8'd3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
